// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: PC load/select, stage-buffer hold/flush, load-use stalls,
// control-flow redirects and the interrupt drain/push/vector entry.
//
// state          | meaning
// RST_LOAD       | first clock after reset: load PC from the reset vector word
// RUN            | normal issue; redirects, load-use stalls, interrupt entry
// INT_DRAIN      | let older instructions retire before the push
// INT_PUSH_PC    | memory stage pushes the return PC
// INT_PUSH_FLAGS | memory stage pushes the flags
// INT_VECTOR     | load PC from the interrupt vector word, acknowledge
module pipeline_hazard_controller #(
  parameter int ADDR_W       = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] f_read_add_1,
  input  logic [ADDR_W-1:0] f_read_add_2,
  input  logic              f_uses_rs1,
  input  logic              f_uses_rs2,
  input  logic              d_mem_read,
  input  logic              d_reg_write,
  input  logic [ADDR_W-1:0] d_write_add,
  input  logic              e_branch_taken,
  input  logic              m_ret,
  output logic              pc_write,
  output logic [1:0]        pc_sel,
  output logic              fd_hold,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              int_push_pc,
  output logic              int_push_flags,
  output logic              int_ack,
  output logic              busy
);

  typedef enum logic [2:0] {
    RST_LOAD, RUN, INT_DRAIN, INT_PUSH_PC, INT_PUSH_FLAGS, INT_VECTOR
  } state_t;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_VEC = 2'd2;
  localparam logic [1:0] PC_POP = 2'd3;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       load_use;
  logic       redirect;

  assign load_use = d_mem_read & d_reg_write &
                    ((f_uses_rs1 & (f_read_add_1 == d_write_add)) |
                     (f_uses_rs2 & (f_read_add_2 == d_write_add)));
  assign redirect = m_ret | e_branch_taken;

  // a new request wins over the acknowledge clear so it is never lost
  assign pend_d = int_req | (pend_q & (state_q != INT_VECTOR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_LOAD;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write       = 1'b0;
    pc_sel         = PC_INC;
    fd_hold        = 1'b0;
    fd_flush       = 1'b0;
    de_flush       = 1'b0;
    int_push_pc    = 1'b0;
    int_push_flags = 1'b0;
    int_ack        = 1'b0;

    case (state_q)
      RST_LOAD: begin
        pc_write = 1'b1;
        pc_sel   = PC_VEC;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_write = 1'b1;
          pc_sel   = m_ret ? PC_POP : PC_BR;
          fd_flush = 1'b1;
          de_flush = 1'b1;
        end else if (pend_q) begin
          fd_flush = 1'b1;
          state_d  = INT_DRAIN;
          cnt_d    = 3'(DRAIN_CYCLES - 1);
        end else if (load_use) begin
          fd_hold  = 1'b1;
          de_flush = 1'b1;
        end else begin
          pc_write = 1'b1;
        end
      end
      INT_DRAIN: begin
        fd_flush = 1'b1;
        // older in-flight redirects still land; the pushed PC becomes their target
        if (redirect) begin
          pc_write = 1'b1;
          pc_sel   = m_ret ? PC_POP : PC_BR;
          de_flush = 1'b1;
        end
        if (cnt_q == 3'd0) begin
          state_d = INT_PUSH_PC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      INT_PUSH_PC: begin
        int_push_pc = 1'b1;
        fd_flush    = 1'b1;
        state_d     = INT_PUSH_FLAGS;
      end
      INT_PUSH_FLAGS: begin
        int_push_flags = 1'b1;
        fd_flush       = 1'b1;
        state_d        = INT_VECTOR;
      end
      INT_VECTOR: begin
        pc_write = 1'b1;
        pc_sel   = PC_VEC;
        int_ack  = 1'b1;
        fd_flush = 1'b1;
        state_d  = RUN;
      end
      default: state_d = RST_LOAD;
    endcase

    if (reset) begin
      pc_write       = 1'b0;
      pc_sel         = PC_VEC;
      fd_hold        = 1'b0;
      fd_flush       = 1'b1;
      de_flush       = 1'b1;
      int_push_pc    = 1'b0;
      int_push_flags = 1'b0;
      int_ack        = 1'b0;
    end
  end

  assign busy = reset | (state_q != RUN);

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed table, hand sequences and
// random stimulus, all checked against a phase-index reference model.
module tb_pipeline_hazard_controller;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       int_req = 1'b0;
  logic [2:0] fa1 = '0, fa2 = '0, dwa = '0;
  logic       u1 = 1'b0, u2 = 1'b0, dmr = 1'b0, drw = 1'b0, br = 1'b0, mr = 1'b0;

  logic       pc_write, fd_hold, fd_flush, de_flush;
  logic       int_push_pc, int_push_flags, int_ack, busy;
  logic [1:0] pc_sel;
  logic [9:0] act;

  int total = 0;
  int bad = 0;

  // model: m_rl = reset-load cycle pending, m_k = 0 in RUN, 1..D drain,
  // D+1 push PC, D+2 push flags, D+3 vector
  bit m_rl = 1'b1;
  int m_k = 0;
  bit m_pend = 1'b0;

  pipeline_hazard_controller #(.ADDR_W(3), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .int_req(int_req),
    .f_read_add_1(fa1), .f_read_add_2(fa2),
    .f_uses_rs1(u1), .f_uses_rs2(u2),
    .d_mem_read(dmr), .d_reg_write(drw), .d_write_add(dwa),
    .e_branch_taken(br), .m_ret(mr),
    .pc_write(pc_write), .pc_sel(pc_sel), .fd_hold(fd_hold),
    .fd_flush(fd_flush), .de_flush(de_flush),
    .int_push_pc(int_push_pc), .int_push_flags(int_push_flags),
    .int_ack(int_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, pc_sel, fd_hold, fd_flush, de_flush,
                int_push_pc, int_push_flags, int_ack, busy};

  localparam logic [9:0] E_RST   = 10'b0100110001;
  localparam logic [9:0] E_RLOAD = 10'b1100110001;
  localparam logic [9:0] E_RUN   = 10'b1000000000;
  localparam logic [9:0] E_STALL = 10'b0001010000;
  localparam logic [9:0] E_BR    = 10'b1010110000;
  localparam logic [9:0] E_RET   = 10'b1110110000;
  localparam logic [9:0] E_ENTRY = 10'b0000100000;
  localparam logic [9:0] E_DRAIN = 10'b0000100001;
  localparam logic [9:0] E_PPC   = 10'b0000101001;
  localparam logic [9:0] E_PFL   = 10'b0000100101;
  localparam logic [9:0] E_VEC   = 10'b1100100011;

  function automatic logic [9:0] pack(bit pw, logic [1:0] ps, bit h, bit ff, bit df,
                                      bit pp, bit pf, bit ack, bit b);
    return {pw, ps, h, ff, df, pp, pf, ack, b};
  endfunction

  function automatic logic [9:0] model_out();
    bit hz;
    hz = dmr && drw && ((u1 && fa1 == dwa) || (u2 && fa2 == dwa));
    if (reset) return pack(0, 2'd2, 0, 1, 1, 0, 0, 0, 1);
    if (m_rl) return pack(1, 2'd2, 0, 1, 1, 0, 0, 0, 1);
    if (m_k <= D && (mr || br)) return pack(1, mr ? 2'd3 : 2'd1, 0, 1, 1, 0, 0, 0, m_k != 0);
    if (m_k == 0) begin
      if (m_pend) return pack(0, 2'd0, 0, 1, 0, 0, 0, 0, 0);
      if (hz) return pack(0, 2'd0, 1, 0, 1, 0, 0, 0, 0);
      return pack(1, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    end
    if (m_k <= D) return pack(0, 2'd0, 0, 1, 0, 0, 0, 0, 1);
    if (m_k == D + 1) return pack(0, 2'd0, 0, 1, 0, 1, 0, 0, 1);
    if (m_k == D + 2) return pack(0, 2'd0, 0, 1, 0, 0, 1, 0, 1);
    return pack(1, 2'd2, 0, 1, 0, 0, 0, 1, 1);
  endfunction

  task automatic idle();
    int_req = 0; fa1 = 0; fa2 = 0; dwa = 0;
    u1 = 0; u2 = 0; dmr = 0; drw = 0; br = 0; mr = 0;
  endtask

  // one clock: compare mid-cycle, advance the model, return just after the edge
  task automatic cycle(input string nm, input bit use_t, input logic [9:0] texp);
    logic [9:0] e;
    int k_old;
    @(negedge clk);
    e = model_out();
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s model: actual=%b required=%b at %0t", nm, act, e, $time);
    end
    if (use_t) begin
      total++;
      if (act !== texp) begin
        bad++;
        $display("FAIL %s table: actual=%b required=%b at %0t", nm, act, texp, $time);
      end
    end
    total++;
    if (fd_hold && (fd_flush || pc_write)) begin
      bad++;
      $display("FAIL %s invariant: hold=%b flush=%b pc_write=%b required hold exclusive",
               nm, fd_hold, fd_flush, pc_write);
    end
    if (reset) begin
      m_rl = 1; m_k = 0; m_pend = 0;
    end else begin
      k_old = m_k;
      if (m_rl) begin
        m_rl = 0; m_k = 0;
      end else if (m_k == 0) begin
        if (m_pend && !mr && !br) m_k = 1;
      end else if (m_k == D + 3) begin
        m_k = 0;
      end else begin
        m_k++;
      end
      m_pend = int_req || (m_pend && !(!m_rl && k_old == D + 3 && m_k == 0));
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic mr, br, dmr, drw;
    logic [2:0] dwa, fa1, fa2;
    logic u1, u2;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, E_RUN};
    tbl[1] = '{0, 0, 1, 1, 3'd3, 3'd0, 3'd3, 0, 1, E_STALL};
    tbl[2] = '{0, 0, 1, 1, 3'd3, 3'd0, 3'd3, 0, 0, E_RUN};
    tbl[3] = '{0, 1, 1, 1, 3'd3, 3'd0, 3'd3, 0, 1, E_BR};
    tbl[4] = '{1, 1, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, E_RET};
    tbl[5] = '{0, 0, 1, 1, 3'd5, 3'd5, 3'd1, 1, 0, E_STALL};
    tbl[6] = '{0, 0, 1, 0, 3'd5, 3'd5, 3'd1, 1, 0, E_RUN};
    tbl[7] = '{0, 0, 0, 1, 3'd5, 3'd5, 3'd1, 1, 0, E_RUN};
    tbl[8] = '{0, 0, 1, 1, 3'd5, 3'd4, 3'd5, 1, 0, E_RUN};
    tbl[9] = '{1, 0, 1, 1, 3'd2, 3'd2, 3'd2, 1, 1, E_RET};

    idle();
    reset = 1;
    #1;
    for (int i = 0; i < 3; i++) cycle("reset_hold", 1, E_RST);
    reset = 0;
    cycle("rst_load", 1, E_RLOAD);
    cycle("first_run", 1, E_RUN);

    for (int i = 0; i < 10; i++) begin
      mr = tbl[i].mr; br = tbl[i].br; dmr = tbl[i].dmr; drw = tbl[i].drw;
      dwa = tbl[i].dwa; fa1 = tbl[i].fa1; fa2 = tbl[i].fa2;
      u1 = tbl[i].u1; u2 = tbl[i].u2;
      cycle($sformatf("vec%0d", i), 1, tbl[i].exp);
    end
    idle();
    cycle("after_stall", 1, E_RUN);

    // single interrupt pulse: entry, D drains, push PC, push flags, vector, RUN
    int_req = 1;
    cycle("int_req_cycle", 1, E_RUN);
    int_req = 0;
    cycle("int_entry", 1, E_ENTRY);
    for (int i = 0; i < D; i++) cycle("int_drain", 1, E_DRAIN);
    cycle("int_push_pc", 1, E_PPC);
    cycle("int_push_flags", 1, E_PFL);
    cycle("int_vector", 1, E_VEC);
    cycle("int_back_run", 1, E_RUN);

    // request held across PUSH_FLAGS and VECTOR: one RUN cycle then re-entry
    int_req = 1;
    cycle("int2_req", 1, E_RUN);
    int_req = 0;
    cycle("int2_entry", 1, E_ENTRY);
    for (int i = 0; i < D; i++) cycle("int2_drain", 1, E_DRAIN);
    cycle("int2_push_pc", 1, E_PPC);
    int_req = 1;
    cycle("int2_push_flags", 1, E_PFL);
    cycle("int2_vector", 1, E_VEC);
    int_req = 0;
    cycle("int3_entry_run", 1, E_ENTRY);
    cycle("int3_drain", 1, E_DRAIN);
    for (int i = 0; i < D + 2; i++) cycle("int3_rest", 0, '0);
    cycle("int3_back_run", 1, E_RUN);

    // redirect during drain is still honoured
    int_req = 1;
    cycle("int4_req", 1, E_RUN);
    int_req = 0;
    cycle("int4_entry", 1, E_ENTRY);
    br = 1;
    cycle("drain_branch", 1, 10'b1010110001);
    br = 0; mr = 1;
    cycle("drain_ret", 1, 10'b1110110001);
    mr = 0;
    cycle("drain_last", 1, E_DRAIN);
    cycle("int4_push_pc", 1, E_PPC);
    for (int i = 0; i < 2; i++) cycle("int4_rest", 0, '0);

    // reset in the middle of a drain
    int_req = 1;
    cycle("int5_req", 1, E_RUN);
    int_req = 0;
    cycle("int5_entry", 1, E_ENTRY);
    cycle("int5_drain", 1, E_DRAIN);
    reset = 1;
    cycle("mid_drain_reset", 1, E_RST);
    cycle("mid_drain_reset2", 1, E_RST);
    reset = 0;
    cycle("reset2_load", 1, E_RLOAD);
    cycle("reset2_run_no_pend", 1, E_RUN);
    cycle("reset2_run_no_pend2", 1, E_RUN);

    for (int i = 0; i < 3000; i++) begin
      int_req = ($urandom_range(0, 39) == 0);
      mr  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 7) == 0);
      dmr = $urandom_range(0, 1);
      drw = $urandom_range(0, 1);
      u1  = $urandom_range(0, 1);
      u2  = $urandom_range(0, 1);
      dwa = 3'($urandom_range(0, 3));
      fa1 = 3'($urandom_range(0, 3));
      fa2 = 3'($urandom_range(0, 3));
      cycle("random", 0, '0);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
